// File: rtl/imem_loader.sv
// imem_loader -- writer side of the 9-bit instruction store.
//
// Packs a stream of 3-bit symbols (opcode, reg1, reg2) into 9-bit words
// {op, reg1, reg2} and writes them to consecutive addresses from 0.
//
// Ports:
//   clk, rst_n      system clock (rising edge), async active-low reset
//   start           pulse; begins a new load at address 0 (ignored while busy)
//   in_valid/in_ready/in_data/in_last   symbol stream handshake
//   wr_en/wr_addr/wr_data               registered memory write port
//   busy/done/error                     load status (done/error sticky until start)
//   word_count      words written in the current or last load
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// OP    | expecting opcode symbol (or memory full -> ERR on in_valid)
// R1    | expecting reg1 symbol
// R2    | expecting reg2 symbol; accept issues the write
// FIN   | load ended cleanly on a reg2 carrying in_last
// ERR   | truncated word or overflow; load aborted
module imem_loader #(
  parameter int PC_BITS = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [2:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               wr_en,
  output logic [PC_BITS-1:0] wr_addr,
  output logic [8:0]         wr_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [PC_BITS:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_R1   = 3'd2,
    S_R2   = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [PC_BITS:0] C_DEPTH = {1'b1, {PC_BITS{1'b0}}};

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_op;
  logic [2:0]           r_r1;
  logic                 r_wr_en;
  logic [PC_BITS-1:0]   r_wr_addr;
  logic [8:0]           r_wr_data;
  logic [PC_BITS:0]     r_word_count;

  logic w_full;
  logic w_in_ready;
  logic w_accept;
  logic w_clear;
  logic w_write;

  // Memory full: the opcode of a would-be extra word is refused, not accepted.
  assign w_full   = (r_word_count == C_DEPTH);
  assign w_accept = in_valid && w_in_ready;
  assign w_write  = (r_state == S_R2) && w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_clear    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next  = S_OP;
          w_clear = 1'b1;
        end
      end
      S_OP: begin
        busy       = 1'b1;
        w_in_ready = !w_full;
        if (in_valid) begin
          if (w_full)       w_next = S_ERR;
          else if (in_last) w_next = S_ERR;
          else              w_next = S_R1;
        end
      end
      S_R1: begin
        busy       = 1'b1;
        w_in_ready = 1'b1;
        if (in_valid) w_next = in_last ? S_ERR : S_R2;
      end
      S_R2: begin
        busy       = 1'b1;
        w_in_ready = 1'b1;
        if (in_valid) w_next = in_last ? S_FIN : S_OP;
      end
      S_FIN: begin
        done = 1'b1;
        if (start) begin
          w_next  = S_OP;
          w_clear = 1'b1;
        end
      end
      S_ERR: begin
        error = 1'b1;
        if (start) begin
          w_next  = S_OP;
          w_clear = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= '0;
      r_r1         <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
    end else begin
      r_wr_en <= w_write;
      if (r_state == S_OP && w_accept) r_op <= in_data;
      if (r_state == S_R1 && w_accept) r_r1 <= in_data;
      if (w_clear) begin
        r_word_count <= '0;
      end else if (w_write) begin
        // Address is the count before this word; count advances on the same edge.
        r_wr_addr    <= r_word_count[PC_BITS-1:0];
        r_wr_data    <= {r_op, r_r1, in_data};
        r_word_count <= r_word_count + {{PC_BITS{1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int PCB   = 2;
  localparam int DEPTH = 1 << PCB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [2:0]     in_data = 3'd0;
  logic           in_last = 1'b0;
  logic           in_ready, wr_en, busy, done, error;
  logic [PCB-1:0] wr_addr;
  logic [8:0]     wr_data;
  logic [PCB:0]   word_count;

  imem_loader #(.PC_BITS(PCB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
    bit dn;
  } wr_t;

  wr_t got[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) got.push_back('{addr: int'(wr_addr), data: int'(wr_data), cyc: cyc, dn: done});
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = 3'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one symbol and returns at the negedge after it was accepted.
  task automatic send_sym(input logic [2:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    stall_cnt += n;
    if (n >= 50) chk("accept_timeout", n, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference: a load writes every complete triple, at addresses 0,1,2,...
  // trunc: 0 = ends with last on reg2 of word nw-1; 1 = last on opcode of word k;
  //        2 = last on reg1 of word k.
  task automatic rand_load(input int nw, input int trunc, input int maxgap, input string tag);
    int exp_w[$];
    int k;
    logic [2:0] s0, s1, s2;
    got.delete();
    stall_cnt = 0;
    pulse_start();
    k = (trunc != 0) ? int'($urandom_range(0, nw - 1)) : nw;
    for (int w = 0; w < nw; w++) begin
      s0 = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom);
      idle($urandom_range(0, maxgap));
      if (w == k && trunc == 1) begin
        send_sym(s0, 1'b1);
        break;
      end
      send_sym(s0, 1'b0);
      idle($urandom_range(0, maxgap));
      if (w == k && trunc == 2) begin
        send_sym(s1, 1'b1);
        break;
      end
      send_sym(s1, 1'b0);
      idle($urandom_range(0, maxgap));
      send_sym(s2, w == nw - 1);
      exp_w.push_back(int'({s0, s1, s2}));
    end
    idle(3);
    chk({tag, "_nwr"}, got.size(), exp_w.size());
    for (int i = 0; i < got.size() && i < exp_w.size(); i++) begin
      chk({tag, "_addr"}, got[i].addr, i);
      chk({tag, "_data"}, got[i].data, exp_w[i]);
    end
    chk({tag, "_done"}, done, trunc == 0);
    chk({tag, "_error"}, error, trunc != 0);
    chk({tag, "_wc"}, word_count, exp_w.size());
    chk({tag, "_busy"}, busy, 0);
    if (trunc == 0 && got.size() > 0) chk({tag, "_done_align"}, got[got.size()-1].dn, 1);
    if (maxgap == 0) begin
      chk({tag, "_stalls"}, stall_cnt, 0);
      for (int i = 1; i < got.size(); i++) chk({tag, "_spacing"}, got[i].cyc - got[i-1].cyc, 3);
    end
  endtask

  initial begin
    int t0;
    // reset state
    @(negedge clk);
    chk("reset_outs", {in_ready, wr_en, wr_addr, wr_data, busy, done, error, word_count}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-R1 after two words
    got.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_sym(3'(i + 1), 1'b0);
    send_sym(3'd7, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("midload_reset_outs", {in_ready, wr_en, wr_addr, wr_data, busy, done, error, word_count}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("midload_nwr", got.size(), 2);
    // release with start coincident
    got.delete();
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_release_busy", busy, 1);
    send_sym(3'b001, 1'b0);
    send_sym(3'b010, 1'b0);
    send_sym(3'b011, 1'b1);
    idle(2);
    chk("post_reset_nwr", got.size(), 1);
    if (got.size() > 0) begin
      chk("post_reset_addr", got[0].addr, 0);
      chk("post_reset_data", got[0].data, 9'b001010011);
    end
    chk("post_reset_done", done, 1);
    chk("post_reset_wc", word_count, 1);

    // back-to-back four words
    got.delete();
    pulse_start();
    t0 = cyc;
    stall_cnt = 0;
    for (int i = 0; i < 12; i++) send_sym(3'(i), i == 11);
    idle(2);
    chk("b2b_nwr", got.size(), 4);
    for (int i = 0; i < got.size(); i++) begin
      chk("b2b_cycle", got[i].cyc - t0, 3 * i + 3);
      chk("b2b_addr", got[i].addr, i);
      chk("b2b_dn", got[i].dn, i == 3);
    end
    chk("b2b_stalls", stall_cnt, 0);
    chk("b2b_wc", word_count, 4);

    // stall pattern 1,0,0,1,1 across one word
    got.delete();
    pulse_start();
    send_sym(3'd5, 1'b0);
    idle(2);
    chk("stall_nwr_mid", got.size(), 0);
    send_sym(3'd6, 1'b0);
    send_sym(3'd1, 1'b1);
    idle(2);
    chk("stall_nwr", got.size(), 1);
    if (got.size() > 0) chk("stall_data", got[0].data, 9'b101110001);

    // truncation on reg1 after one full word, then restart
    got.delete();
    pulse_start();
    send_sym(3'd2, 1'b0); send_sym(3'd3, 1'b0); send_sym(3'd4, 1'b0);
    send_sym(3'd5, 1'b0); send_sym(3'd6, 1'b1);
    idle(3);
    chk("trunc_error", error, 1);
    chk("trunc_nwr", got.size(), 1);
    chk("trunc_wc", word_count, 1);
    got.delete();
    pulse_start();
    chk("trunc_restart_error", error, 0);
    send_sym(3'd7, 1'b0); send_sym(3'd0, 1'b0); send_sym(3'd7, 1'b1);
    idle(2);
    chk("trunc_restart_nwr", got.size(), 1);
    if (got.size() > 0) chk("trunc_restart_addr", got[0].addr, 0);

    // overflow: DEPTH words without last, then a further opcode
    got.delete();
    pulse_start();
    for (int i = 0; i < 3 * DEPTH; i++) send_sym(3'($urandom), 1'b0);
    in_valid = 1'b1;
    in_data  = 3'd3;
    in_last  = 1'b0;
    #1 chk("ovf_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovf_error", error, 1);
    chk("ovf_wc", word_count, DEPTH);
    chk("ovf_nwr", got.size(), DEPTH);
    rand_load(DEPTH, 0, 0, "full_fin");

    // start ignored while busy (pulse while in R2)
    got.delete();
    pulse_start();
    send_sym(3'd1, 1'b0); send_sym(3'd2, 1'b0); send_sym(3'd3, 1'b0);
    send_sym(3'd4, 1'b0); send_sym(3'd5, 1'b0);
    pulse_start();
    chk("busy_start_wc", word_count, 1);
    send_sym(3'd6, 1'b1);
    idle(2);
    chk("busy_start_nwr", got.size(), 2);
    if (got.size() > 1) begin
      chk("busy_start_addr", got[1].addr, 1);
      chk("busy_start_data", got[1].data, 9'b100101110);
    end
    chk("busy_start_done", done, 1);

    // randomized loads
    for (int it = 0; it < 30; it++)
      rand_load($urandom_range(1, DEPTH), $urandom_range(0, 2), $urandom_range(0, 2), "rand");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
